// File: rtl/alu_trace_pkg.sv
// Shared opcode, class and trace-entry definitions for the ALU trace buffer.
// Optional feature macro: ALU_TRACE_DISPLAY_EN (adds the mnemonic helper used for capture logging).
package alu_trace_pkg;

  localparam int FUNC_W = 6;

  localparam logic [FUNC_W-1:0] ALUFUNC_ADD = 6'h00;
  localparam logic [FUNC_W-1:0] ALUFUNC_SUB = 6'h01;
  localparam logic [FUNC_W-1:0] ALUFUNC_AND = 6'h08;
  localparam logic [FUNC_W-1:0] ALUFUNC_OR  = 6'h09;
  localparam logic [FUNC_W-1:0] ALUFUNC_XOR = 6'h0A;
  localparam logic [FUNC_W-1:0] ALUFUNC_NOR = 6'h0B;
  localparam logic [FUNC_W-1:0] ALUFUNC_A   = 6'h0C;
  localparam logic [FUNC_W-1:0] ALUFUNC_SLL = 6'h10;
  localparam logic [FUNC_W-1:0] ALUFUNC_SRL = 6'h11;
  localparam logic [FUNC_W-1:0] ALUFUNC_SRA = 6'h12;
  localparam logic [FUNC_W-1:0] ALUFUNC_EQ  = 6'h18;
  localparam logic [FUNC_W-1:0] ALUFUNC_NEQ = 6'h19;
  localparam logic [FUNC_W-1:0] ALUFUNC_LT  = 6'h1A;
  localparam logic [FUNC_W-1:0] ALUFUNC_LEZ = 6'h1B;
  localparam logic [FUNC_W-1:0] ALUFUNC_GEZ = 6'h1C;
  localparam logic [FUNC_W-1:0] ALUFUNC_GTZ = 6'h1D;

  typedef enum logic [1:0] {
    CLASS_ARITH = 2'd0,
    CLASS_LOGIC = 2'd1,
    CLASS_SHIFT = 2'd2,
    CLASS_CMP   = 2'd3
  } alu_class_e;

  // Operand/result words depend on WIDTH, so they live beside this in the buffer storage.
  typedef struct packed {
    logic [FUNC_W-1:0] alu_func;
    logic              is_signed;
    logic              mismatch;
  } trace_entry_t;

  function automatic alu_class_e alu_class(input logic [FUNC_W-1:0] func);
    case (func)
      ALUFUNC_AND, ALUFUNC_OR, ALUFUNC_XOR, ALUFUNC_NOR, ALUFUNC_A: return CLASS_LOGIC;
      ALUFUNC_SLL, ALUFUNC_SRL, ALUFUNC_SRA:                        return CLASS_SHIFT;
      ALUFUNC_EQ, ALUFUNC_NEQ, ALUFUNC_LT,
      ALUFUNC_LEZ, ALUFUNC_GEZ, ALUFUNC_GTZ:                        return CLASS_CMP;
      default:                                                      return CLASS_ARITH;
    endcase
  endfunction

  function automatic logic is_legal(input logic [FUNC_W-1:0] func);
    case (func)
      ALUFUNC_ADD, ALUFUNC_SUB, ALUFUNC_AND, ALUFUNC_OR, ALUFUNC_XOR, ALUFUNC_NOR,
      ALUFUNC_A, ALUFUNC_SLL, ALUFUNC_SRL, ALUFUNC_SRA, ALUFUNC_EQ, ALUFUNC_NEQ,
      ALUFUNC_LT, ALUFUNC_LEZ, ALUFUNC_GEZ, ALUFUNC_GTZ: return 1'b1;
      default:                                           return 1'b0;
    endcase
  endfunction

`ifdef ALU_TRACE_DISPLAY_EN
  function automatic string alu_mnemonic(input logic [FUNC_W-1:0] func);
    case (func)
      ALUFUNC_ADD: return "ADD";
      ALUFUNC_SUB: return "SUB";
      ALUFUNC_AND: return "AND";
      ALUFUNC_OR:  return "OR";
      ALUFUNC_XOR: return "XOR";
      ALUFUNC_NOR: return "NOR";
      ALUFUNC_A:   return "A";
      ALUFUNC_SLL: return "SLL";
      ALUFUNC_SRL: return "SRL";
      ALUFUNC_SRA: return "SRA";
      ALUFUNC_EQ:  return "EQ";
      ALUFUNC_NEQ: return "NEQ";
      ALUFUNC_LT:  return "LT";
      ALUFUNC_LEZ: return "LEZ";
      ALUFUNC_GEZ: return "GEZ";
      ALUFUNC_GTZ: return "GTZ";
      default:     return "ILLEGAL";
    endcase
  endfunction
`endif

endpackage

// File: rtl/alu_trace_buffer_if.sv
// Capture and read bus of the ALU trace buffer.
// master = trace source / reader, slave = the buffer itself.
interface alu_trace_buffer_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
);
  logic                       cap_valid;
  logic [WIDTH-1:0]           cap_A;
  logic [WIDTH-1:0]           cap_B;
  logic [WIDTH-1:0]           cap_S;
  logic [5:0]                 cap_ALUFunc;
  logic                       cap_Signed;
  logic                       freeze;

  logic                       rd_valid;
  logic                       rd_ready;
  logic [WIDTH-1:0]           rd_A;
  logic [WIDTH-1:0]           rd_B;
  logic [WIDTH-1:0]           rd_S;
  logic [5:0]                 rd_ALUFunc;
  logic                       rd_Signed;
  logic                       rd_mismatch;

  logic [$clog2(DEPTH+1)-1:0] count;
  logic                       overflow;
  logic [CNT_W-1:0]           err_cnt;

  modport master (
    output cap_valid, cap_A, cap_B, cap_S, cap_ALUFunc, cap_Signed, freeze, rd_ready,
    input  rd_valid, rd_A, rd_B, rd_S, rd_ALUFunc, rd_Signed, rd_mismatch,
    input  count, overflow, err_cnt
  );

  modport slave (
    input  cap_valid, cap_A, cap_B, cap_S, cap_ALUFunc, cap_Signed, freeze, rd_ready,
    output rd_valid, rd_A, rd_B, rd_S, rd_ALUFunc, rd_Signed, rd_mismatch,
    output count, overflow, err_cnt
  );
endinterface

// File: rtl/alu_ref_model.sv
// Combinational reference ALU: the result the captured operation should have produced,
// plus a flag for opcodes outside the defined set.
module alu_ref_model
  import alu_trace_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Signed,
  input  logic [5:0]       ALUFunc,
  output logic [WIDTH-1:0] expected,
  output logic             illegal
);
  localparam int SH_W = $clog2(WIDTH);

  logic [SH_W-1:0]  w_shamt;
  logic             w_lt;
  logic             w_cmp;
  logic [WIDTH-1:0] w_arith;
  logic [WIDTH-1:0] w_logic;
  logic [WIDTH-1:0] w_shift;

  assign w_shamt = A[SH_W-1:0];
  assign w_lt    = Signed ? ($signed(A) < $signed(B)) : (A < B);

  // NOTE: every variable gets a value on every path through this block, so no latch is inferred.
  always_comb begin
    w_arith = (ALUFunc == ALUFUNC_SUB) ? A - B : A + B;

    case (ALUFunc)
      ALUFUNC_AND: w_logic = A & B;
      ALUFUNC_OR:  w_logic = A | B;
      ALUFUNC_XOR: w_logic = A ^ B;
      ALUFUNC_NOR: w_logic = ~(A | B);
      default:     w_logic = A;
    endcase

    case (ALUFunc)
      ALUFUNC_SLL: w_shift = B << w_shamt;
      ALUFUNC_SRL: w_shift = B >> w_shamt;
      default:     w_shift = $unsigned($signed(B) >>> w_shamt);
    endcase

    // Zero tests treat A as signed regardless of cap_Signed.
    case (ALUFunc)
      ALUFUNC_EQ:  w_cmp = (A == B);
      ALUFUNC_NEQ: w_cmp = (A != B);
      ALUFUNC_LT:  w_cmp = w_lt;
      ALUFUNC_LEZ: w_cmp = A[WIDTH-1] | (A == '0);
      ALUFUNC_GEZ: w_cmp = ~A[WIDTH-1];
      default:     w_cmp = ~A[WIDTH-1] & (A != '0);
    endcase

    case (alu_class(ALUFunc))
      CLASS_LOGIC: expected = w_logic;
      CLASS_SHIFT: expected = w_shift;
      CLASS_CMP:   expected = {{(WIDTH-1){1'b0}}, w_cmp};
      default:     expected = w_arith;
    endcase

    illegal = ~is_legal(ALUFunc);
  end

endmodule

// File: rtl/alu_trace_buffer.sv
// Circular trace buffer of ALU transactions with show-ahead read port, overwrite-oldest
// on overflow and a saturating mismatch counter. Macro ALU_TRACE_DISPLAY_EN logs captures.
module alu_trace_buffer
  import alu_trace_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  alu_trace_buffer_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam logic [OCC_W-1:0] FULL_CNT = OCC_W'(DEPTH);

  logic [WIDTH-1:0] r_mem_a    [DEPTH];
  logic [WIDTH-1:0] r_mem_b    [DEPTH];
  logic [WIDTH-1:0] r_mem_s    [DEPTH];
  trace_entry_t     r_mem_meta [DEPTH];

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [OCC_W-1:0] r_count;
  logic             r_overflow;
  logic [CNT_W-1:0] r_err_cnt;

  logic             w_cap;
  logic             w_pop;
  logic             w_full;
  logic             w_valid;
  logic             w_mismatch;
  logic             w_illegal;
  logic [WIDTH-1:0] w_expected;
  trace_entry_t     w_entry;
  trace_entry_t     w_head;

  alu_ref_model #(.WIDTH(WIDTH)) u_ref (
    .A        (bus.cap_A),
    .B        (bus.cap_B),
    .Signed   (bus.cap_Signed),
    .ALUFunc  (bus.cap_ALUFunc),
    .expected (w_expected),
    .illegal  (w_illegal)
  );

  assign w_valid    = (r_count != '0);
  assign w_full     = (r_count == FULL_CNT);
  assign w_cap      = bus.cap_valid & ~bus.freeze;
  assign w_pop      = w_valid & bus.rd_ready;
  assign w_mismatch = w_illegal | (w_expected != bus.cap_S);

  assign w_entry.alu_func  = bus.cap_ALUFunc;
  assign w_entry.is_signed = bus.cap_Signed;
  assign w_entry.mismatch  = w_mismatch;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_err_cnt  <= '0;
    end else begin
      if (w_cap) r_wr_ptr <= r_wr_ptr + 1'b1;
      // A capture into a full buffer without a pop evicts the oldest entry.
      if (w_pop || (w_cap && w_full)) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_cap && !w_pop && !w_full) r_count <= r_count + 1'b1;
      else if (w_pop && !w_cap)       r_count <= r_count - 1'b1;
      if (w_cap && w_full && !w_pop) r_overflow <= 1'b1;
      if (w_cap && w_mismatch && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  // NOTE: storage has no reset; the read port is masked while empty, so stale words never leak.
  always_ff @(posedge clk) begin
    if (w_cap) begin
      r_mem_a[r_wr_ptr]    <= bus.cap_A;
      r_mem_b[r_wr_ptr]    <= bus.cap_B;
      r_mem_s[r_wr_ptr]    <= bus.cap_S;
      r_mem_meta[r_wr_ptr] <= w_entry;
    end
  end

  assign w_head          = w_valid ? r_mem_meta[r_rd_ptr] : '0;
  assign bus.rd_valid    = w_valid;
  assign bus.rd_A        = w_valid ? r_mem_a[r_rd_ptr] : '0;
  assign bus.rd_B        = w_valid ? r_mem_b[r_rd_ptr] : '0;
  assign bus.rd_S        = w_valid ? r_mem_s[r_rd_ptr] : '0;
  assign bus.rd_ALUFunc  = w_head.alu_func;
  assign bus.rd_Signed   = w_head.is_signed;
  assign bus.rd_mismatch = w_head.mismatch;
  assign bus.count       = r_count;
  assign bus.overflow    = r_overflow;
  assign bus.err_cnt     = r_err_cnt;

`ifdef ALU_TRACE_DISPLAY_EN
  always_ff @(posedge clk) begin
    if (!reset && w_cap) begin
      if (w_mismatch)
        $display("%s %s A=%b (%0d) B=%b (%0d) S=%b (%0d) MISMATCH expected=%0d",
                 alu_mnemonic(bus.cap_ALUFunc), bus.cap_Signed ? "Signed" : "Unsigned",
                 bus.cap_A, bus.cap_A, bus.cap_B, bus.cap_B, bus.cap_S, bus.cap_S, w_expected);
      else
        $display("%s %s A=%b (%0d) B=%b (%0d) S=%b (%0d)",
                 alu_mnemonic(bus.cap_ALUFunc), bus.cap_Signed ? "Signed" : "Unsigned",
                 bus.cap_A, bus.cap_A, bus.cap_B, bus.cap_B, bus.cap_S, bus.cap_S);
    end
  end
`endif

endmodule

// File: tb/tb_alu_trace_buffer.sv
// Scoreboard bench for alu_trace_buffer (DEPTH=4, CNT_W=4 so overwrite and saturation are reachable).
module tb_alu_trace_buffer;
  import alu_trace_pkg::*;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int CNT_W = 4;
  localparam int ERR_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset;

  alu_trace_buffer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

  alu_trace_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] s;
    logic [5:0]  f;
    logic        sg;
    logic        mm;
  } sb_t;

  sb_t  sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  logic m_ovf    = 1'b0;
  int   m_err    = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Independent golden ALU: bitwise shift loops, borrow-based compare.
  function automatic logic [31:0] golden(input logic [5:0] f, input logic [31:0] a,
                                         input logic [31:0] b, input logic sg, output logic bad);
    logic [31:0] r;
    logic [31:0] msk;
    logic [32:0] diff;
    int          sh;
    r   = '0;
    bad = 1'b0;
    sh  = int'(a[4:0]);
    msk = sg ? 32'h8000_0000 : 32'h0;
    case (f)
      ALUFUNC_ADD: r = a + b;
      ALUFUNC_SUB: r = a + ~b + 32'd1;
      ALUFUNC_AND: r = a & b;
      ALUFUNC_OR:  r = a | b;
      ALUFUNC_XOR: r = a ^ b;
      ALUFUNC_NOR: r = ~(a | b);
      ALUFUNC_A:   r = a;
      ALUFUNC_SLL: for (int i = 0; i < 32; i++) if (i >= sh) r[i] = b[i-sh];
      ALUFUNC_SRL: for (int i = 0; i < 32; i++) if (i + sh < 32) r[i] = b[i+sh];
      ALUFUNC_SRA: for (int i = 0; i < 32; i++) r[i] = (i + sh < 32) ? b[i+sh] : b[31];
      ALUFUNC_EQ:  r[0] = (a == b);
      ALUFUNC_NEQ: r[0] = (a != b);
      ALUFUNC_LT: begin
        diff = {1'b0, a ^ msk} - {1'b0, b ^ msk};
        r[0] = diff[32];
      end
      ALUFUNC_LEZ: r[0] = a[31] || (a == 32'd0);
      ALUFUNC_GEZ: r[0] = !a[31];
      ALUFUNC_GTZ: r[0] = !a[31] && (a != 32'd0);
      default:     bad = 1'b1;
    endcase
    return r;
  endfunction

  // One clock cycle: drive inputs, check the head mid-cycle, update the model at the edge,
  // then check occupancy and sticky status just after the edge.
  task automatic step(input logic cap, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] s, input logic [5:0] f, input logic sg,
                      input logic frz, input logic rdy, input string tag);
    sb_t         e;
    logic        bad;
    logic [31:0] ex;
    logic        pop;
    bus.cap_valid   = cap;
    bus.cap_A       = a;
    bus.cap_B       = b;
    bus.cap_S       = s;
    bus.cap_ALUFunc = f;
    bus.cap_Signed  = sg;
    bus.freeze      = frz;
    bus.rd_ready    = rdy;
    #1;
    check({tag, "_rd_valid"}, 64'(bus.rd_valid), 64'(sb.size() > 0));
    if (sb.size() > 0) begin
      check({tag, "_head_A"},  64'(bus.rd_A),        64'(sb[0].a));
      check({tag, "_head_B"},  64'(bus.rd_B),        64'(sb[0].b));
      check({tag, "_head_S"},  64'(bus.rd_S),        64'(sb[0].s));
      check({tag, "_head_F"},  64'(bus.rd_ALUFunc),  64'(sb[0].f));
      check({tag, "_head_sg"}, 64'(bus.rd_Signed),   64'(sb[0].sg));
      check({tag, "_head_mm"}, 64'(bus.rd_mismatch), 64'(sb[0].mm));
    end
    pop  = rdy && (sb.size() > 0);
    ex   = golden(f, a, b, sg, bad);
    e.a  = a;
    e.b  = b;
    e.s  = s;
    e.f  = f;
    e.sg = sg;
    e.mm = bad || (ex !== s);
    @(posedge clk);
    if (pop) void'(sb.pop_front());
    if (cap && !frz) begin
      if (!pop && sb.size() == DEPTH) begin
        void'(sb.pop_front());
        m_ovf = 1'b1;
      end
      sb.push_back(e);
      if (e.mm && m_err < ERR_MAX) m_err++;
    end
    #1;
    check({tag, "_count"},    64'(bus.count),    64'(sb.size()));
    check({tag, "_overflow"}, 64'(bus.overflow), 64'(m_ovf));
    check({tag, "_err_cnt"},  64'(bus.err_cnt),  64'(m_err));
  endtask

  task automatic idle_pop(input string tag);
    step(1'b0, 32'd0, 32'd0, 32'd0, ALUFUNC_ADD, 1'b0, 1'b0, 1'b1, tag);
  endtask

  logic [5:0] codes [17] = '{ALUFUNC_ADD, ALUFUNC_SUB, ALUFUNC_AND, ALUFUNC_OR, ALUFUNC_XOR,
                             ALUFUNC_NOR, ALUFUNC_A, ALUFUNC_SLL, ALUFUNC_SRL, ALUFUNC_SRA,
                             ALUFUNC_EQ, ALUFUNC_NEQ, ALUFUNC_LT, ALUFUNC_LEZ, ALUFUNC_GEZ,
                             ALUFUNC_GTZ, 6'h3F};

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] ra, rb, rs, rex;
    logic [5:0]  rf;
    logic        rbad;

    reset           = 1'b1;
    bus.cap_valid   = 1'b0;
    bus.cap_A       = '0;
    bus.cap_B       = '0;
    bus.cap_S       = '0;
    bus.cap_ALUFunc = '0;
    bus.cap_Signed  = 1'b0;
    bus.freeze      = 1'b0;
    bus.rd_ready    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_count",    64'(bus.count),    64'd0);
    check("rst_rd_valid", 64'(bus.rd_valid), 64'd0);
    check("rst_overflow", 64'(bus.overflow), 64'd0);
    check("rst_err_cnt",  64'(bus.err_cnt),  64'd0);
    check("rst_rd_S",     64'(bus.rd_S),     64'd0);
    reset = 1'b0;

    // Correct ADD is visible the next cycle with no mismatch.
    step(1'b1, 32'd5, 32'd7, 32'd12, ALUFUNC_ADD, 1'b0, 1'b0, 1'b0, "add");
    check("add_rd_valid", 64'(bus.rd_valid),    64'd1);
    check("add_rd_S",     64'(bus.rd_S),        64'd12);
    check("add_mm",       64'(bus.rd_mismatch), 64'd0);
    check("add_err",      64'(bus.err_cnt),     64'd0);
    idle_pop("add_pop");

    // SRA fills with the sign: expected 0xF8000000, so S=0x08000000 is a mismatch.
    step(1'b1, 32'd4, 32'h8000_0000, 32'h0800_0000, ALUFUNC_SRA, 1'b0, 1'b0, 1'b0, "sra");
    check("sra_mm",  64'(bus.rd_mismatch), 64'd1);
    check("sra_err", 64'(bus.err_cnt),     64'd1);
    idle_pop("sra_pop");

    // LT -1 < 1 holds signed, fails unsigned.
    step(1'b1, 32'hFFFF_FFFF, 32'd1, 32'd1, ALUFUNC_LT, 1'b1, 1'b0, 1'b0, "lt_s");
    step(1'b1, 32'hFFFF_FFFF, 32'd1, 32'd1, ALUFUNC_LT, 1'b0, 1'b0, 1'b0, "lt_u");
    check("lt_s_mm", 64'(bus.rd_mismatch), 64'd0);
    idle_pop("lt_pop0");
    check("lt_u_mm", 64'(bus.rd_mismatch), 64'd1);
    idle_pop("lt_pop1");
    check("lt_err", 64'(bus.err_cnt), 64'd2);

    // Full buffer with capture and pop together: count holds, no overflow, oldest leaves.
    for (int k = 0; k < 4; k++)
      step(1'b1, 32'd0, 32'(10 + k), 32'(10 + k), ALUFUNC_ADD, 1'b0, 1'b0, 1'b0, "fill");
    check("full_count", 64'(bus.count),    64'd4);
    check("full_head",  64'(bus.rd_S),     64'd10);
    step(1'b1, 32'd0, 32'd20, 32'd20, ALUFUNC_ADD, 1'b0, 1'b0, 1'b1, "cap_pop");
    check("cap_pop_count", 64'(bus.count),    64'd4);
    check("cap_pop_ovf",   64'(bus.overflow), 64'd0);
    check("cap_pop_head",  64'(bus.rd_S),     64'd11);
    for (int k = 0; k < 4; k++) idle_pop("drain1");

    // Six captures into four slots: the two oldest are overwritten.
    for (int k = 1; k <= 6; k++)
      step(1'b1, 32'd0, 32'(k), 32'(k), ALUFUNC_ADD, 1'b0, 1'b0, 1'b0, "ovf_cap");
    check("ovf_count", 64'(bus.count),    64'd4);
    check("ovf_flag",  64'(bus.overflow), 64'd1);
    for (int k = 3; k <= 6; k++) begin
      check("ovf_read", 64'(bus.rd_S), 64'(k));
      idle_pop("ovf_pop");
    end
    check("drained_valid", 64'(bus.rd_valid), 64'd0);
    check("drained_ovf",   64'(bus.overflow), 64'd1);

    // Random mix including an illegal opcode, freeze, and err_cnt saturation.
    for (int n = 0; n < 80; n++) begin
      ra  = $urandom;
      rb  = $urandom;
      rf  = codes[$urandom_range(0, 16)];
      rex = golden(rf, ra, rb, 1'b0, rbad);
      rs  = ($urandom_range(0, 1) == 1) ? rex : $urandom;
      step($urandom_range(0, 3) != 0, ra, rb, rs, rf, 1'($urandom_range(0, 1)),
           $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)), "rand");
    end

    // Mid-stream reset with three entries, after freeze-gated captures.
    while (sb.size() > 0) idle_pop("drain2");
    step(1'b1, 32'd1, 32'd1, 32'd2, ALUFUNC_ADD, 1'b0, 1'b0, 1'b0, "pre_rst");
    step(1'b1, 32'd2, 32'd2, 32'd4, ALUFUNC_ADD, 1'b0, 1'b0, 1'b0, "pre_rst");
    step(1'b1, 32'd9, 32'd9, 32'd0, ALUFUNC_ADD, 1'b0, 1'b1, 1'b0, "frozen");
    check("frozen_count", 64'(bus.count), 64'd2);
    step(1'b1, 32'd3, 32'd3, 32'd6, ALUFUNC_ADD, 1'b0, 1'b0, 1'b0, "pre_rst");
    check("pre_rst_count", 64'(bus.count), 64'd3);
    #3;
    reset         = 1'b1;
    bus.cap_valid = 1'b1;
    bus.rd_ready  = 1'b1;
    #1;
    sb.delete();
    m_ovf = 1'b0;
    m_err = 0;
    check("async_count",    64'(bus.count),    64'd0);
    check("async_rd_valid", 64'(bus.rd_valid), 64'd0);
    check("async_rd_S",     64'(bus.rd_S),     64'd0);
    check("async_overflow", 64'(bus.overflow), 64'd0);
    check("async_err_cnt",  64'(bus.err_cnt),  64'd0);
    @(posedge clk);
    #1;
    check("in_rst_count", 64'(bus.count), 64'd0);
    #2;
    reset = 1'b0;
    step(1'b1, 32'd4, 32'd4, 32'd8, ALUFUNC_ADD, 1'b0, 1'b1, 1'b0, "post_frz");
    step(1'b1, 32'd4, 32'd4, 32'd8, ALUFUNC_ADD, 1'b0, 1'b0, 1'b0, "post_cap");
    check("post_rd_S", 64'(bus.rd_S), 64'd8);
    idle_pop("post_pop");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_trace_buffer.md
ALU_TRACE_BUFFER -- requirements
Module: alu_trace_buffer

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width (>=8).
REQ-002 SHALL have parameter DEPTH, default 16, trace entries (power of two, >=2).
REQ-003 SHALL have parameter CNT_W, default 16, error counter width.
REQ-004 SHALL have port clk  input  1  single clock, rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port cap_valid  input  1  capture strobe, one transaction per cycle.
REQ-007 SHALL have ports cap_A, cap_B, cap_S  input  WIDTH each  ALU operands and observed result.
REQ-008 SHALL have ports cap_ALUFunc  input  6, and cap_Signed  input  1.
REQ-009 SHALL have port freeze  input  1  while high, captures are ignored.
REQ-010 SHALL have ports rd_valid  output  1, and rd_ready  input  1  read handshake.
REQ-011 SHALL have ports rd_A, rd_B, rd_S  output  WIDTH; rd_ALUFunc  output  6; rd_Signed, rd_mismatch  output  1  head entry.
REQ-012 SHALL have ports count  output  $clog2(DEPTH+1)  occupancy; overflow  output  1  sticky; err_cnt  output  CNT_W  mismatches.

Function
REQ-013 SHALL write an entry on each rising clk with cap_valid=1 and freeze=0; it is visible at the read port on the following cycle.
REQ-014 SHALL present the oldest entry on rd_* combinationally from storage (show-ahead); rd_valid=1 iff count>0.
REQ-015 SHALL pop the head on rd_valid&&rd_ready; rd_ready while empty has no effect.
REQ-016 SHALL, on capture when full with no pop, overwrite the oldest entry, advance the head, keep count=DEPTH, and set overflow.
REQ-017 SHALL, on simultaneous capture and pop, leave count unchanged, including when full; overflow is not set.
REQ-018 SHALL wrap read/write pointers modulo DEPTH.
REQ-019 SHALL compute the expected result from cap_* in the same cycle: ADD/SUB modulo 2^WIDTH; AND, OR, XOR, NOR bitwise; A passes cap_A.
REQ-020 SHALL compute shifts as cap_B shifted by cap_A[$clog2(WIDTH)-1:0]: SLL and SRL fill with zero, SRA fills with the sign.
REQ-021 SHALL compute compares as zero-extended 1-bit results: EQ/NEQ on A,B; LT signed if cap_Signed, else unsigned; LEZ/GEZ/GTZ compare A with 0, signed.
REQ-022 SHALL store mismatch=1 with the entry when expected != cap_S, or when ALUFunc is not one of the 16 defined codes.
REQ-023 SHALL increment err_cnt on each captured mismatch, saturating at all-ones; this includes captures that overwrite.
REQ-024 SHALL keep overflow and err_cnt until reset; draining the buffer does not clear them.

Reset
REQ-025 SHALL, on reset assertion, immediately clear pointers, count, overflow and err_cnt; rd_valid=0, and rd_* data is don't-care but deterministic (zero).
REQ-026 SHALL discard any capture or pop in a cycle where reset is asserted; operation resumes on the first clk edge after deassertion.

Configuration
REQ-027 SHALL, with macro ALU_TRACE_DISPLAY_EN defined, $display on each accepted capture: the mnemonic, Signed/Unsigned, A, B and S in binary and decimal, and "MISMATCH expected=<v>" when applicable.
REQ-028 SHALL, without ALU_TRACE_DISPLAY_EN, contain no system tasks; the RTL is synthesizable and port behaviour is identical.

Structure
REQ-029 SHALL place the 6-bit ALUFUNC_* codes, the 2-bit class codes (ARITH, LOGIC, SHIFT, CMP) and the trace entry struct in shared package alu_trace_pkg.
REQ-030 SHALL implement expected-result computation in combinational sub-module alu_ref_model (params WIDTH; in: A, B, Signed, ALUFunc; out: expected, illegal).

Verification
REQ-031 SHALL cover: capture ADD A=5,B=7,S=12 -> next cycle rd_valid=1, rd_S=12, rd_mismatch=0, err_cnt=0.
REQ-032 SHALL cover: capture SRA A=4, B=0x80000000, S=0x08000000 -> rd_mismatch=1, err_cnt=1 (expected 0xF8000000).
REQ-033 SHALL cover: DEPTH=4, 6 captures with S=1..6, no reads -> count=4, overflow=1, reads return S=3,4,5,6.
REQ-034 SHALL cover: full buffer with capture and pop in the same cycle -> count stays 4, overflow stays 0, popped entry is the oldest.
REQ-035 SHALL cover: LT A=0xFFFFFFFF, B=1, S=1, Signed=1 then Signed=0 -> first entry mismatch=0, second mismatch=1.
REQ-036 SHALL cover: reset asserted mid-stream with count=3 and freeze toggled -> count=0, rd_valid=0 immediately; captures during freeze are not stored.
